// File: rtl/lfsr_gen.sv
// Configurable Fibonacci/Galois LFSR with reseed, MISR signature mode and a
// counted burst sequencer (IDLE -> RUN -> DONE).
module lfsr_gen #(
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0]  POLY  = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0]  SEED  = '1,
    parameter int unsigned       CW    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             misr_en,
    input  logic [WIDTH-1:0] misr_in,
    input  logic             start,
    input  logic [CW-1:0]    nsteps,
    output logic [WIDTH-1:0] state,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic             seed_hit
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic             busy_q, done_q, hit_q, hit_d;
    logic             do_step;

    logic [WIDTH-1:0] fib_nxt, gal_nxt, sel_nxt, step_nxt;

    assign fib_nxt = {lfsr_q[WIDTH-2:0], ^(lfsr_q & POLY)};
    assign gal_nxt = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? POLY : '0);
    assign sel_nxt = mode ? gal_nxt : fib_nxt;

    // Zero is a fixed point of both forms; recover to SEED unless a signature
    // is being folded in, where the raw XOR result must be kept.
    always_comb begin
        step_nxt = sel_nxt;
        if (misr_en)
            step_nxt = sel_nxt ^ misr_in;
        else if (lfsr_q == '0)
            step_nxt = SEED;
    end

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        do_step = 1'b0;
        if (load) begin
            lfsr_d = load_val;
            fsm_d  = IDLE;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        cnt_d = nsteps;
                        fsm_d = (nsteps == '0) ? DONE : RUN;
                    end else if (en) begin
                        do_step = 1'b1;
                    end
                end
                RUN: begin
                    do_step = 1'b1;
                    cnt_d   = cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        fsm_d = DONE;
                end
                DONE:    fsm_d = IDLE;
                default: fsm_d = IDLE;
            endcase
            if (do_step)
                lfsr_d = step_nxt;
        end
    end

    assign hit_d = do_step && (step_nxt == SEED);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            lfsr_q <= SEED;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hit_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            lfsr_q <= lfsr_d;
            busy_q <= (fsm_d == RUN);
            done_q <= (fsm_d == DONE);
            hit_q  <= hit_d;
        end
    end

    assign state    = lfsr_q;
    assign sout     = lfsr_q[WIDTH-1];
    assign busy     = busy_q;
    assign done     = done_q;
    assign seed_hit = hit_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: two 4-bit instances (Fibonacci-tuned and Galois-tuned
// polynomials) share stimulus and are checked against a cycle-level model.
module tb_lfsr_gen;

    localparam int W = 4;
    localparam int C = 8;
    localparam int unsigned SEED = 1;

    logic         CLK = 1'b0;
    logic         RST, en, mode, load, misr_en, start;
    logic [W-1:0] load_val, misr_in;
    logic [C-1:0] nsteps;
    logic [W-1:0] st_f, st_g;
    logic         so_f, so_g, bz_f, bz_g, dn_f, dn_g, hit_f, hit_g;

    always #5 CLK = ~CLK;

    lfsr_gen #(.WIDTH(W), .POLY(4'b1001), .SEED(4'b0001), .CW(C)) dut_f (
        .CLK(CLK), .RST(RST), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .misr_en(misr_en), .misr_in(misr_in), .start(start), .nsteps(nsteps),
        .state(st_f), .sout(so_f), .busy(bz_f), .done(dn_f), .seed_hit(hit_f));

    lfsr_gen #(.WIDTH(W), .POLY(4'b0011), .SEED(4'b0001), .CW(C)) dut_g (
        .CLK(CLK), .RST(RST), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .misr_en(misr_en), .misr_in(misr_in), .start(start), .nsteps(nsteps),
        .state(st_g), .sout(so_g), .busy(bz_g), .done(dn_g), .seed_hit(hit_g));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: integer LFSR arithmetic plus a burst phase
    // (0 = waiting, 1 = bursting, 2 = just finished) and remaining step count.
    int unsigned polys[2] = '{9, 3};
    int unsigned ms[2];
    bit          mhit[2];
    bit          mbusy, mdone;
    int          ph, left;

    function automatic int unsigned step_fn(input int unsigned s, input int unsigned poly,
                                            input bit m, input bit me, input int unsigned mi);
        int unsigned r;
        if (!m) r = ((s * 2) % 16) + ($countones(s & poly) % 2);
        else begin
            r = (s * 2) % 16;
            if (s >= 8) r = r ^ poly;
        end
        if (me) return r ^ mi;
        if (s == 0) return SEED;
        return r;
    endfunction

    task automatic advance();
        for (int k = 0; k < 2; k++) begin
            ms[k]   = step_fn(ms[k], polys[k], mode, misr_en, misr_in);
            mhit[k] = (ms[k] == SEED);
        end
    endtask

    task automatic model_edge();
        if (!RST) begin
            ms[0] = SEED; ms[1] = SEED;
            mhit[0] = 0; mhit[1] = 0;
            ph = 0; left = 0; mbusy = 0; mdone = 0;
            return;
        end
        mhit[0] = 0; mhit[1] = 0;
        if (load) begin
            ms[0] = load_val; ms[1] = load_val; ph = 0;
        end else if (ph == 0) begin
            if (start) begin
                left = int'(nsteps);
                ph   = (nsteps == 0) ? 2 : 1;
            end else if (en) advance();
        end else if (ph == 1) begin
            advance();
            left--;
            if (left == 0) ph = 2;
        end else ph = 0;
        mbusy = (ph == 1);
        mdone = (ph == 2);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        chk("f.state", st_f, ms[0]);
        chk("g.state", st_g, ms[1]);
        chk("f.sout", so_f, (ms[0] >> 3) & 1);
        chk("g.sout", so_g, (ms[1] >> 3) & 1);
        chk("f.busy", bz_f, mbusy);
        chk("g.busy", bz_g, mbusy);
        chk("f.done", dn_f, mdone);
        chk("g.done", dn_g, mdone);
        chk("f.seed_hit", hit_f, mhit[0]);
        chk("g.seed_hit", hit_g, mhit[1]);
    endtask

    logic [3:0] fib_tab[4] = '{4'h3, 4'h7, 4'hF, 4'hE};
    logic [3:0] gal_tab[4] = '{4'h2, 4'h4, 4'h8, 4'h3};

    initial begin
        int bc, dc;
        RST = 0; en = 0; mode = 0; load = 0; load_val = '0;
        misr_en = 0; misr_in = '0; start = 0; nsteps = '0;

        tick(); tick();
        chk("rst.state", st_f, 4'b0001);
        chk("rst.busy", bz_f, 0);
        chk("rst.done", dn_f, 0);
        chk("rst.hit", hit_f, 0);
        RST = 1;

        // Fibonacci, POLY 1001: known prefix, SEED returns after 15 steps
        mode = 0; en = 1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i <= 4) chk("fib.seq", st_f, fib_tab[i-1]);
            chk("fib.hit", hit_f, (i == 15));
        end
        chk("fib.period", st_f, 4'b0001);

        // Galois, POLY 0011
        RST = 0; tick(); RST = 1;
        mode = 1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i <= 4) chk("gal.seq", st_g, gal_tab[i-1]);
            chk("gal.hit", hit_g, (i == 15));
        end
        chk("gal.period", st_g, 4'b0001);

        // Load zero, then recover on the next step
        en = 0; mode = 0; load = 1; load_val = 4'h0;
        tick();
        chk("ld0.state", st_f, 4'h0);
        chk("ld0.hit", hit_f, 0);
        load = 0; en = 1;
        tick();
        chk("recov.f", st_f, 4'b0001);
        chk("recov.g", st_g, 4'b0001);
        en = 0;

        // Burst of 5 with en toggling
        start = 1; nsteps = 5;
        tick();
        start = 0;
        bc = int'(bz_f); dc = 0;
        for (int i = 0; i < 8; i++) begin
            en = 1'($urandom);
            tick();
            bc += int'(bz_f);
            dc += int'(dn_f);
            if (i == 4) chk("b5.done_at", dn_f, 1);
        end
        chk("b5.busy_cycles", bc, 5);
        chk("b5.done_cycles", dc, 1);
        en = 0;

        // Zero-length burst
        start = 1; nsteps = 0;
        tick();
        start = 0;
        chk("b0.done", dn_f, 1);
        chk("b0.busy", bz_f, 0);
        tick();
        chk("b0.done_clr", dn_f, 0);

        // Reset during a burst
        start = 1; nsteps = 10;
        tick();
        start = 0;
        repeat (3) tick();
        RST = 0;
        tick();
        RST = 1;
        chk("rstrun.state", st_f, 4'b0001);
        chk("rstrun.busy", bz_f, 0);
        dc = 0;
        repeat (12) begin tick(); dc += int'(dn_f); end
        chk("rstrun.nodone", dc, 0);

        // Load during a burst
        start = 1; nsteps = 10;
        tick();
        start = 0;
        repeat (3) tick();
        load = 1; load_val = 4'hA;
        tick();
        load = 0;
        chk("ldrun.state", st_f, 4'hA);
        chk("ldrun.busy", bz_f, 0);
        dc = 0;
        repeat (12) begin tick(); dc += int'(dn_f); end
        chk("ldrun.nodone", dc, 0);

        // Signature mode from zero: no recovery
        load = 1; load_val = 4'h0;
        tick();
        load = 0; misr_en = 1; misr_in = 4'b1010; mode = 0; en = 1;
        tick();
        chk("misr.f", st_f, 4'b1010);
        chk("misr.g", st_g, 4'b1010);
        for (int i = 0; i < 20; i++) begin
            misr_in = 4'($urandom);
            mode    = 1'($urandom);
            tick();
        end
        misr_en = 0; en = 0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            RST      = ($urandom_range(0, 99) != 0);
            load     = ($urandom_range(0, 19) == 0);
            load_val = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            start    = ($urandom_range(0, 7) == 0);
            nsteps   = C'($urandom_range(0, 6));
            en       = 1'($urandom);
            mode     = 1'($urandom);
            misr_en  = ($urandom_range(0, 3) == 0);
            misr_in  = 4'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 8: LFSR state width, legal range 3..32.
REQ-002 Parameter POLY, default 8'hB8: tap/polynomial mask, WIDTH bits; bit i = 1 selects tap i.
REQ-003 Parameter SEED, default all-ones: reset and lock-up recovery state, must be nonzero.
REQ-004 Parameter CW, default 16: width of the burst step counter.
REQ-005 Port CLK input 1: clock; all state SHALL update on the rising edge only.
REQ-006 Port RST input 1: reset, synchronous, active-low.
REQ-007 Port en input 1: free-run step enable, honoured in IDLE only.
REQ-008 Port mode input 1: 0 = Fibonacci, 1 = Galois; sampled on every step.
REQ-009 Port load input 1: reseed strobe.
REQ-010 Port load_val input WIDTH: reseed value.
REQ-011 Port misr_en input 1: when 1, XOR misr_in into every step (signature mode).
REQ-012 Port misr_in input WIDTH: signature data.
REQ-013 Port start input 1: burst request; honoured in IDLE only.
REQ-014 Port nsteps input CW: burst length, sampled with start.
REQ-015 Port state output WIDTH: current LFSR register.
REQ-016 Port sout output 1: state[WIDTH-1].
REQ-017 Port busy output 1: high in RUN.
REQ-018 Port done output 1: one-cycle pulse on burst completion.
REQ-019 Port seed_hit output 1: one-cycle pulse when a step produces a state equal to SEED.

Function
REQ-020 Fibonacci step SHALL be next = {s[WIDTH-2:0], ^(s & POLY)}.
REQ-021 Galois step SHALL be next = {s[WIDTH-2:0],1'b0} ^ (s[WIDTH-1] ? POLY : 0).
REQ-022 With misr_en=1, next SHALL be the selected step XOR misr_in.
REQ-023 With misr_en=0, a step from state 0 SHALL yield SEED (lock-up recovery), never 0.
REQ-024 FSM states SHALL be IDLE, RUN, DONE; reset enters IDLE.
REQ-025 IDLE: en=1 steps once per cycle; start=1 loads counter with nsteps and enters RUN the next cycle; start takes priority over en in that cycle and performs no step.
REQ-026 start with nsteps=0 SHALL go directly to DONE, with zero steps.
REQ-027 RUN: steps every cycle regardless of en; counter decrements per step; the step that takes the counter from 1 to 0 moves to DONE, so exactly nsteps steps occur.
REQ-028 DONE: no step; done=1 for exactly this cycle; return to IDLE next cycle.
REQ-029 load=1 in any state SHALL write load_val to state, suppress the step, and force IDLE; a RUN burst is aborted without a done pulse.
REQ-030 load_val=0 is accepted as-is; recovery per REQ-023 applies only on the next step.
REQ-031 seed_hit SHALL be asserted in the cycle after the step whose result equals SEED; loads never assert it.
REQ-032 busy SHALL be registered, equal to (FSM==RUN).

Reset
REQ-033 While RST=0 at a rising edge: state<=SEED, FSM<=IDLE, counter<=0, busy=0, done=0, seed_hit=0; reset overrides load, start, and en.
REQ-034 Reset during RUN SHALL abort the burst without a done pulse.

Verification
REQ-035 WIDTH=4, POLY=4'b1001, SEED=4'b0001, mode=0, en=1: states 0011, 0111, 1111, 1110 …; seed_hit on the 15th step; period 15.
REQ-036 Same params, mode=1, POLY=4'b0011: 0001 -> 0010 -> 0100 -> 1000 -> 0011; period 15.
REQ-037 load=1, load_val=0, then en=1 with misr_en=0 -> state 0 for one cycle, then SEED; no zero lock.
REQ-038 start with nsteps=5 -> busy high for 5 cycles, 5 steps, done high for 1 cycle, IDLE; en toggling during RUN has no effect; nsteps=0 -> done the cycle after start.
REQ-039 RST=0 asserted on RUN cycle 3 of a 10-step burst -> state=SEED, busy=0, no done pulse; load on RUN cycle 3 -> state=load_val, busy=0, no done pulse.
REQ-040 misr_en=1, state=0, misr_in=4'b1010, mode=0 -> next state 1010 (no recovery); compare signature against a reference model.
